// File: rtl/node_activation_accumulator.sv
// rtl/node_activation_accumulator.sv - sums NUM_TERMS node results onto a bias, applies clipped ReLU, one activation per frame
module node_activation_accumulator #(
  parameter int DATA_W    = 10,
  parameter int NUM_TERMS = 4,
  parameter int ACC_W     = 17
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  input  logic [DATA_W-1:0]                bias,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_clip,
  output logic [$clog2(NUM_TERMS+1)-1:0]   term_cnt
);

  localparam int CNT_W = $clog2(NUM_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  if (NUM_TERMS < 1 || NUM_TERMS > 64 || ACC_W < DATA_W + $clog2(NUM_TERMS) + 1) begin : g_bad_params
    $error("node_activation_accumulator: illegal NUM_TERMS/ACC_W combination");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] data_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic                    sum_neg;
  logic                    sum_over;
  logic [DATA_W-1:0]       sat_data;
  logic                    accept;
  logic                    last_term;

  assign accept    = in_valid & in_ready;
  assign last_term = (term_cnt == LAST_CNT);

  // Bias only enters on the first term, so mid-frame bias changes are ignored.
  always_comb begin
    bias_ext = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};
    data_ext = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
    base     = (term_cnt == '0) ? bias_ext : acc;
    sum      = base + data_ext;
  end

  always_comb begin
    sum_neg  = sum[ACC_W-1];
    sum_over = (sum > OUT_MAX);
    if (sum_neg) begin
      sat_data = '0;
    end else if (sum_over) begin
      sat_data = OUT_MAX[DATA_W-1:0];
    end else begin
      sat_data = sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_term) begin
          next_state = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = ACCUM;
        end
      end
      default: next_state = ACCUM;
    endcase
  end

  // out_data/out_clip only load on frame completion, so they hold through OUT and after the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      term_cnt <= '0;
      out_data <= '0;
      out_clip <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      if (last_term) begin
        term_cnt <= '0;
        out_data <= sat_data;
        out_clip <= sum_over;
      end else begin
        term_cnt <= term_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_node_activation_accumulator.sv
// tb/tb_node_activation_accumulator.sv - scoreboard bench for node_activation_accumulator
module tb_node_activation_accumulator;

  localparam int DATA_W = 10;
  localparam int NUM_TERMS = 4;
  localparam int ACC_W = 17;
  localparam int WAIT_MAX = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] bias;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_clip;
  logic [2:0]        term_cnt;

  int checks = 0;
  int failures = 0;

  logic [DATA_W:0] sb[$];
  int frame_sum;

  always #5 clk = ~clk;

  node_activation_accumulator #(
    .DATA_W(DATA_W), .NUM_TERMS(NUM_TERMS), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_clip(out_clip), .term_cnt(term_cnt)
  );

  // Reference: {clip, data} for a full-precision integer frame sum.
  function automatic logic [DATA_W:0] model(input int s);
    if (s < 0) return {1'b0, 10'd0};
    if (s > 511) return {1'b1, 10'd511};
    return {1'b0, 10'(s)};
  endfunction

  // Called at a negedge; presents one term for exactly one clock.
  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = 10'(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int b, input int t0, input int t1, input int t2, input int t3);
    bias = 10'(b);
    frame_sum = b + t0 + t1 + t2 + t3;
    sb.push_back(model(frame_sum));
    send(t0); send(t1); send(t2); send(t3);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 10'd0 || out_clip !== 1'b0 || term_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset: valid=%b ready=%b data=%0d clip=%b cnt=%0d, want 0 1 0 0 0",
               out_valid, in_ready, out_data, out_clip, term_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_latency;
    logic [DATA_W:0] exp;
    out_ready = 1'b1;
    send_frame(10, 5, 6, 7, 8);
    exp = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp[9:0] || out_clip !== exp[10]) begin
      failures++;
      $display("FAIL basic: valid=%b ready=%b data=%0d clip=%b, want 1 0 %0d %b",
               out_valid, in_ready, out_data, out_clip, exp[9:0], exp[10]);
    end
    checks++;
    if (exp[9:0] !== 10'd36) begin
      failures++;
      $display("FAIL basic_model: model=%0d want 36", exp[9:0]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 10'd36) begin
      failures++;
      $display("FAIL basic_after: valid=%b ready=%b data=%0d, want 0 1 36", out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_gaps;
    int terms[4] = '{-100, -50, 20, 10};
    logic [DATA_W:0] exp;
    int n;
    bias = 10'd0;
    sb.push_back(model(-120));
    for (int i = 0; i < 4; i++) begin
      send(terms[i]);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          checks++;
          if (term_cnt !== 3'(i + 1)) begin
            failures++;
            $display("FAIL gaps_cnt: term %0d gap %0d cnt=%0d want %0d", i, g, term_cnt, i + 1);
          end
          @(negedge clk);
        end
      end
    end
    n = 0;
    while (out_valid !== 1'b1 && n < WAIT_MAX) begin @(negedge clk); n++; end
    exp = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp[9:0] || out_clip !== exp[10]) begin
      failures++;
      $display("FAIL gaps_out: valid=%b data=%0d clip=%b, want 1 %0d %b", out_valid, out_data, out_clip, exp[9:0], exp[10]);
    end
    @(negedge clk);
  endtask

  task automatic test_clip;
    logic [DATA_W:0] exp;
    send_frame(500, 100, 100, 100, -511);
    exp = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp[9:0] || out_clip !== exp[10] || out_data !== 10'd289) begin
      failures++;
      $display("FAIL clip_289: valid=%b data=%0d clip=%b, want 1 289 0", out_valid, out_data, out_clip);
    end
    @(negedge clk);
    send_frame(500, 100, 100, 100, 100);
    exp = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp[9:0] || out_clip !== exp[10] || out_clip !== 1'b1) begin
      failures++;
      $display("FAIL clip_high: valid=%b data=%0d clip=%b, want 1 511 1", out_valid, out_data, out_clip);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [DATA_W:0] exp;
    out_ready = 1'b0;
    send_frame(3, 1, 2, 3, 4);
    exp = sb.pop_front();
    in_valid = 1'b1;
    in_data  = 10'd99;
    bias     = 10'd200;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || term_cnt !== 3'd0 ||
          out_data !== exp[9:0] || out_clip !== exp[10]) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d valid=%b ready=%b cnt=%0d data=%0d, want 1 0 0 %0d",
                 c, out_valid, in_ready, term_cnt, out_data, exp[9:0]);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || term_cnt !== 3'd0) begin
      failures++;
      $display("FAIL bp_release: valid=%b ready=%b cnt=%0d, want 0 1 0", out_valid, in_ready, term_cnt);
    end
    send_frame(7, 10, 20, 30, 40);
    exp = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp[9:0] || out_clip !== exp[10]) begin
      failures++;
      $display("FAIL bp_next: valid=%b data=%0d clip=%b, want 1 %0d %b", out_valid, out_data, out_clip, exp[9:0], exp[10]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [DATA_W:0] exp;
    bias = 10'd10;
    send(50);
    send(50);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (term_cnt !== 3'd0 || out_valid !== 1'b0 || out_data !== 10'd0) begin
      failures++;
      $display("FAIL midreset: cnt=%0d valid=%b data=%0d, want 0 0 0", term_cnt, out_valid, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(1, 1, 1, 1, 1);
    exp = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp[9:0] || out_data !== 10'd5 || out_clip !== exp[10]) begin
      failures++;
      $display("FAIL midreset_frame: valid=%b data=%0d clip=%b, want 1 5 0", out_valid, out_data, out_clip);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [DATA_W:0] exp;
    int n;
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send_frame($signed(10'($urandom)), $signed(10'($urandom)), $signed(10'($urandom)),
                 $signed(10'($urandom)), $signed(10'($urandom)));
      n = 0;
      while (out_valid !== 1'b1 && n < WAIT_MAX) begin @(negedge clk); n++; end
      exp = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[9:0] || out_clip !== exp[10]) begin
        failures++;
        $display("FAIL b2b frame %0d: valid=%b data=%0d clip=%b, want 1 %0d %b (sum %0d)",
                 f, out_valid, out_data, out_clip, exp[9:0], exp[10], frame_sum);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic_latency;
    test_gaps;
    test_clip;
    test_backpressure;
    test_reset_midframe;
    test_back_to_back;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
